// File: rtl/imem_fetch_ctrl.sv
// Sequential instruction fetch from a combinational IMEM into a one-entry output buffer.
// Capture lands 1 cycle after issue; the buffer holds while decode stalls, and a redirect flushes it.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] fetch_count,
  output logic        state_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_out_valid;
  logic        w_out_valid_nxt;
  logic [31:0] r_out_pc;
  logic [31:0] w_out_pc_nxt;
  logic [31:0] r_out_inst;
  logic [31:0] w_out_inst_nxt;
  logic [31:0] r_fetch_count;
  logic        w_slot_free;
  logic        w_xfer;

  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_xfer      = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_out_valid   <= 1'b0;
      r_out_pc      <= 32'h0;
      r_out_inst    <= 32'h0;
      r_fetch_count <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_inst  <= w_out_inst_nxt;
      // A transfer accepted in a flush cycle still counts.
      if (w_xfer) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = en ? S_FETCH : S_IDLE;
    w_pc_nxt        = r_pc;
    w_out_valid_nxt = r_out_valid;
    w_out_pc_nxt    = r_out_pc;
    w_out_inst_nxt  = r_out_inst;

    if (redirect_valid) begin
      w_pc_nxt        = {redirect_pc[31:2], 2'b00};
      w_out_valid_nxt = 1'b0;
    end else if (r_state == S_FETCH) begin
      if (w_slot_free) begin
        w_out_pc_nxt    = r_pc;
        w_out_inst_nxt  = imem_inst;
        w_out_valid_nxt = 1'b1;
        w_pc_nxt        = r_pc + PC_INC;
      end
    end else begin
      w_out_valid_nxt = r_out_valid & ~out_ready;
    end
  end

  assign imem_pc     = r_pc;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_inst    = r_out_inst;
  assign fetch_count = r_fetch_count;
  assign state_o     = r_state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: stimulus queues expected transfers, a negedge monitor pops and checks them.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] fetch_count;
  logic        state_o;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  imem_fetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .PC_INC  (32'd4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .imem_pc       (imem_pc),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .fetch_count   (fetch_count),
    .state_o       (state_o)
  );

  // IMEM word is a scrambled copy of its address so pc and inst mix-ups show up.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  assign imem_inst = inst_of(imem_pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("xfer_pc", out_pc, e);
        chk("xfer_inst", out_inst, inst_of(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #3;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_imem_pc", imem_pc, 32'h0);
    chk("rst_fetch_count", fetch_count, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_state", {31'h0, state_o}, 32'h0);
    #9 rst_n = 1'b1;
    cyc();
    chk("idle_after_rst", {31'h0, state_o}, 32'h0);

    // Streaming with a 3-cycle stall at pc 8.
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h10);
    en = 1'b1; out_ready = 1'b1;
    cyc();
    chk("enter_fetch", {31'h0, state_o}, 32'h1);
    chk("first_not_valid", {31'h0, out_valid}, 32'h0);
    cyc();
    chk("first_valid", {31'h0, out_valid}, 32'h1);
    chk("first_pc", out_pc, 32'h0);
    cyc();
    cyc();
    chk("pre_stall_pc", out_pc, 32'h8);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_out_pc", out_pc, 32'h8);
      chk("stall_out_inst", out_inst, inst_of(32'h8));
      chk("stall_imem_pc", imem_pc, 32'hC);
    end
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("count_after_stream", fetch_count, 32'd5);

    // Redirect to an unaligned target while stalled.
    exp_q.push_back(32'h100);
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    cyc();
    chk("redir_flush", {31'h0, out_valid}, 32'h0);
    chk("redir_imem_pc", imem_pc, 32'h100);
    redirect_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("redir_valid", {31'h0, out_valid}, 32'h1);
    chk("redir_out_pc", out_pc, 32'h100);
    cyc();
    out_ready = 1'b0;

    // Redirect, stall and en falling together.
    redirect_valid = 1'b1; redirect_pc = 32'h200; en = 1'b0;
    cyc();
    chk("combo_state", {31'h0, state_o}, 32'h0);
    chk("combo_flush", {31'h0, out_valid}, 32'h0);
    chk("combo_imem_pc", imem_pc, 32'h200);
    redirect_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("idle_no_capture", {31'h0, out_valid}, 32'h0);
    chk("idle_pc_hold", imem_pc, 32'h200);
    chk("count_after_combo", fetch_count, 32'd6);

    // PC wrap, then a redirect on a cycle that also transfers.
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc();
    chk("wrap_state", {31'h0, state_o}, 32'h1);
    chk("wrap_imem_pc", imem_pc, 32'hFFFF_FFF8);
    redirect_valid = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("wrap_out_pc", out_pc, 32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    chk("flush_xfer_count", fetch_count, 32'd10);
    chk("flush_xfer_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_xfer_imem_pc", imem_pc, 32'h40);
    redirect_valid = 1'b0;

    // Asynchronous reset mid-stream.
    exp_q.push_back(32'h40);
    cyc(); cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_fetch_count", fetch_count, 32'h0);
    chk("arst_imem_pc", imem_pc, 32'h0);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_state", {31'h0, state_o}, 32'h0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC loaded on reset.
REQ-002 Parameter: PC_INC, 4, sequential PC increment.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  fetch enable; 0 = no new fetches.
REQ-006 imem_pc  output  32  address to combinational IMEM; equals internal PC register.
REQ-007 imem_inst  input  32  IMEM read data for imem_pc, valid in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  32  redirect target; bits [1:0] forced to 0 internally.
REQ-010 out_valid  output  1  out_pc/out_inst hold a fetched instruction.
REQ-011 out_ready  input  1  decode stage accepts the instruction this cycle.
REQ-012 out_pc  output  32  PC of the buffered instruction.
REQ-013 out_inst  output  32  buffered instruction word.
REQ-014 fetch_count  output  32  number of instructions accepted by decode (out_valid & out_ready), wraps modulo 2^32.
REQ-015 state_o  output  1  0 = IDLE, 1 = FETCH.

Function
REQ-016 FSM has two states: IDLE and FETCH; IDLE->FETCH when en=1, FETCH->IDLE when en=0, both taking effect at the next edge.
REQ-017 Output buffer is one entry; a transfer occurs in any cycle with out_valid=1 and out_ready=1.
REQ-018 "slot_free" = (out_valid=0) or (out_ready=1).
REQ-019 In FETCH with redirect_valid=0 and slot_free=1: out_pc<=PC, out_inst<=imem_inst, out_valid<=1, PC<=PC+PC_INC.
REQ-020 In FETCH with slot_free=0: PC, out_pc, out_inst and out_valid hold (stall); imem_pc stays stable.
REQ-021 redirect_valid=1 in any state: PC<={redirect_pc[31:2],2'b00}, out_valid<=0 (flush), no capture that cycle; redirect has priority over capture and stall.
REQ-022 In IDLE (no redirect): no capture, PC holds; out_valid<=out_valid & ~out_ready (pending entry drains).
REQ-023 Throughput: one instruction per cycle when en=1, out_ready=1, no redirect; first out_valid appears 1 cycle after entering FETCH.
REQ-024 PC arithmetic is 32-bit unsigned; PC+PC_INC wraps from 32'hFFFFFFFC to 32'h00000000 without error.
REQ-025 fetch_count increments on each transfer, including the cycle a redirect flushes the entry (transfer already accepted).
REQ-026 out_pc/out_inst are don't-care while out_valid=0 but hold their last value (no X after reset).

Reset
REQ-027 rst_n=0 asynchronously forces: PC=RESET_PC, state=IDLE, out_valid=0, out_pc=0, out_inst=0, fetch_count=0.
REQ-028 Reset asserted mid-operation discards the buffered instruction and any in-flight redirect; outputs reach reset values without a clock edge.
REQ-029 After rst_n deasserts, the first capture occurs no earlier than the second rising edge (edge 1: IDLE->FETCH if en=1).

Verification
REQ-030 Reset, en=1, out_ready=1, IMEM word = address: out_pc sequence 0,4,8,12 on consecutive cycles, out_inst matches, fetch_count=4 after 4 transfers.
REQ-031 Stall: out_ready=0 for 3 cycles with out_pc=8 -> out_pc/out_inst/imem_pc (12) stable for 3 cycles, then resume 12,16.
REQ-032 Redirect to 32'h00000103 while out_valid=1, out_ready=0 -> next cycle out_valid=0, imem_pc=32'h00000100; following cycle out_pc=32'h100.
REQ-033 Simultaneous redirect and stall and en falling -> redirect applied, state IDLE, out_valid=0, no capture.
REQ-034 Wrap: redirect to 32'hFFFFFFF8 -> out_pc FFFFFFF8, FFFFFFFC, 00000000.
REQ-035 Assert rst_n=0 mid-stream between edges -> out_valid, fetch_count, imem_pc return to 0 immediately.
